// File: rtl/vote_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : vote_collector_if
// Description : Signal bundle between a ballot source/consumer and the
//               vote_collector ballot-capture stage.
//               sw_in  - raw asynchronous voter switches (bit i = voter i)
//               start  - request to open a voting window
//               sw3    - latched ballot for the majority voter
//               valid  - one-cycle pulse when sw3 has just been updated
//               busy   - high while the voting window is open
//               master : drives sw_in/start, observes sw3/valid/busy
//               slave  : the vote_collector side
// Revision    : 1.0 - initial release
// ============================================================================
interface vote_collector_if;
    logic [2:0] sw_in;
    logic       start;
    logic [2:0] sw3;
    logic       valid;
    logic       busy;

    modport master (
        output sw_in,
        output start,
        input  sw3,
        input  valid,
        input  busy
    );

    modport slave (
        input  sw_in,
        input  start,
        output sw3,
        output valid,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/vote_collector.sv
`default_nettype none
// ============================================================================
// Module      : vote_collector
// Description : Ballot-capture stage ahead of the three-input majority voter.
//               Each raw switch is synchronised (2 flops) and debounced, then
//               a fixed-length voting window is opened on start. When the
//               window closes the tally is latched onto sw3 and flagged with
//               a one-cycle valid pulse.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - vote_collector_if.slave (sw_in, start, sw3, valid,
//                       busy)
// Parameters  : DB_CYC  - stable cycles required before a debounced change
//               WIN_CYC - voting window length in cycles
// Options     : VOTE_LOCK_EN - when defined, a 1 seen on any voter during
//               the window is latched (no retraction); otherwise the ballot
//               is the debounced value in the last open cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_collector #(
    parameter int DB_CYC  = 1000000,
    parameter int WIN_CYC = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    vote_collector_if.slave  bus
);

    localparam int DB_W  = $clog2(DB_CYC + 1);
    localparam int WIN_W = $clog2(WIN_CYC + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous switches
    // ------------------------------------------------------------------
    logic [2:0] sync1;
    logic [2:0] s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            s     <= 3'b000;
        end else begin
            sync1 <= bus.sw_in;
            s     <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-voter debouncer: the synchronised level must differ from the
    // debounced level for DB_CYC consecutive cycles before it is adopted.
    // Any agreeing cycle clears the count, so a glitch restarts it.
    // ------------------------------------------------------------------
    logic [2:0] db;

    for (genvar i = 0; i < 3; i++) begin : g_bit
        logic [DB_W-1:0] cnt;
        logic            db_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt  <= '0;
                db_q <= 1'b0;
            end else if (s[i] == db_q) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                db_q <= s[i];
                cnt  <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end

        assign db[i] = db_q;
    end

    // ------------------------------------------------------------------
    // Tally for the current open cycle
    // ------------------------------------------------------------------
    logic [2:0] next_tally;

`ifdef VOTE_LOCK_EN
    logic [2:0] tally;
    assign next_tally = tally | db;
`else
    assign next_tally = db;
`endif

    // ------------------------------------------------------------------
    // Window FSM with registered outputs
    // ------------------------------------------------------------------
    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic [2:0]       sw3_q;
    logic             valid_q;
    logic             busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            win_cnt <= '0;
`ifdef VOTE_LOCK_EN
            tally   <= 3'b000;
`endif
            sw3_q   <= 3'b000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        state   <= OPEN;
                        win_cnt <= '0;
`ifdef VOTE_LOCK_EN
                        tally   <= 3'b000;
`endif
                        busy_q  <= 1'b1;
                    end
                end
                OPEN: begin
                    win_cnt <= win_cnt + WIN_W'(1);
`ifdef VOTE_LOCK_EN
                    tally   <= next_tally;
`endif
                    // next_tally already includes db of this last open cycle
                    if (win_cnt == WIN_LAST) begin
                        state   <= DONE;
                        sw3_q   <= next_tally;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sw3   = sw3_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_collector
// Description : Self-checking bench for vote_collector (DB_CYC=4,
//               WIN_CYC=16). Expected ballots are queued when a window is
//               started; a monitor pops and compares on every valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_collector;

    localparam int DB_CYC  = 4;
    localparam int WIN_CYC = 16;

`ifdef VOTE_LOCK_EN
    localparam logic [2:0] RETRACT_EXP = 3'b110;
`else
    localparam logic [2:0] RETRACT_EXP = 3'b010;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vote_collector_if bus ();

    vote_collector #(
        .DB_CYC  (DB_CYC),
        .WIN_CYC (WIN_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         v0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every valid pulse must match the oldest queued ballot
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("valid_without_ballot", 32'(bus.valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("ballot", 32'(bus.sw3), 32'(mon_exp));
            end
        end
    end

    // One window started at the current negedge (cycle T). Optionally
    // pulses start again at T+5 and T+17 (both must be ignored).
    task automatic window(input logic [2:0] exp, input bit extra_starts);
        exp_q.push_back(exp);
        bus.start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cyc(1);
            check($sformatf("busy_T+%0d", k), 32'(bus.busy), 32'(k <= WIN_CYC));
            if (k == 16) check("valid_early", 32'(bus.valid), 32'd0);
            if (k == 17) check("valid_T+17", 32'(bus.valid), 32'd1);
            bus.start = extra_starts && (k == 5 || k == 17);
        end
        cyc(1);
        check("valid_T+18", 32'(bus.valid), 32'd0);
        check("busy_T+18", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.sw_in = 3'b111;
        bus.start = 1'b0;
        rst_n     = 1'b0;

        // ---------------- reset ----------------
        cyc(3);
        check("reset_sw3", 32'(bus.sw3), 32'd0);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_db", 32'(dut.db), 32'd0);
        rst_n = 1'b1;
        cyc(5);
        check("db_release_5", 32'(dut.db), 32'd0);
        cyc(1);
        check("db_release_6", 32'(dut.db), 32'h7);
        check("sw3_no_window", 32'(bus.sw3), 32'd0);
        check("valid_no_window", 32'(bus.valid), 32'd0);

        // ---------------- bounce ----------------
        bus.sw_in = 3'b000;
        cyc(10);
        check("db_cleared", 32'(dut.db), 32'd0);
        for (int k = 0; k < 10; k++) begin
            bus.sw_in = (k % 2 == 0) ? 3'b001 : 3'b000;
            cyc(1);
            check($sformatf("bounce_%0da", k), 32'(dut.db[0]), 32'd0);
            cyc(1);
            check($sformatf("bounce_%0db", k), 32'(dut.db[0]), 32'd0);
        end
        bus.sw_in = 3'b001;
        cyc(5);
        check("bounce_final_5", 32'(dut.db[0]), 32'd0);
        cyc(1);
        check("bounce_final_6", 32'(dut.db[0]), 32'd1);

        // ---------------- basic window ----------------
        bus.sw_in = 3'b011;
        cyc(10);
        check("db_011", 32'(dut.db), 32'h3);
        window(3'b011, 1'b0);
        bus.sw_in = 3'b100;
        cyc(10);
        check("sw3_holds_011", 32'(bus.sw3), 32'h3);

        // ---------------- retraction ----------------
        bus.sw_in = 3'b110;
        cyc(10);
        exp_q.push_back(RETRACT_EXP);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
        bus.sw_in = 3'b010;
        cyc(15);
        check("retract_sw3", 32'(bus.sw3), 32'(RETRACT_EXP));

        // ---------------- ignored start ----------------
        cyc(5);
        v0 = n_valid;
        window(3'b010, 1'b1);
        check("one_valid_per_window", 32'(n_valid - v0), 32'd1);
        // start driven at T+18 must open a new window
        window(3'b010, 1'b0);

        // ---------------- mid-window reset ----------------
        bus.sw_in = 3'b101;
        cyc(10);
        v0 = n_valid;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(7);
        check("busy_before_reset", 32'(bus.busy), 32'd1);
        check("sw3_before_reset", 32'(bus.sw3), 32'h2);
        rst_n = 1'b0;
        #1;
        check("busy_async_reset", 32'(bus.busy), 32'd0);
        check("sw3_async_reset", 32'(bus.sw3), 32'd0);
        check("valid_async_reset", 32'(bus.valid), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(30);
        check("no_valid_after_reset", 32'(n_valid - v0), 32'd0);
        check("sw3_after_reset", 32'(bus.sw3), 32'd0);
        check("busy_after_reset", 32'(bus.busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vote_collector.md
# vote_collector

Upstream ballot-capture stage for the three-input majority voter. Takes three raw, bouncing voter switches and a start pulse, and produces a clean 3-bit ballot that stays stable for the voter's `sw3` input. Each switch is synchronised and debounced. The block then opens a fixed-length voting window, latches the ballot when the window closes, and flags it with a one-cycle `valid` pulse.

## Interface
- `DB_CYC`, 1000000 — cycles a synchronised switch level must stay constant before the debounced value changes; legal range ≥1.
- `WIN_CYC`, 50000000 — voting window length in clock cycles; legal range ≥1.
- `clk`  in  1  single system clock; every flop is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low; deassertion is synchronous to `clk` externally.
- `sw_in`  in  3  raw voter switches; asynchronous; bit i belongs to voter i.
- `start`  in  1  synchronous active-high request to open a voting window; level is sampled every cycle.
- `sw3`  out  3  latched ballot; drives the voter's `sw3` input.
- `valid`  out  1  one-cycle pulse when `sw3` has just been updated.
- `busy`  out  1  high while the voting window is open.

## Operation
- Synchroniser: each `sw_in[i]` passes through a 2-flop synchroniser, giving `s[i]`.
- Debouncer, one per bit, giving `db[i]`:
  - Counter width is clog2(DB_CYC+1).
  - While `s[i] == db[i]`, the counter is held at 0.
  - Otherwise the counter increments each cycle. When it reaches DB_CYC-1 on a cycle where `s[i]` still differs, `db[i]` takes `s[i]` and the counter clears.
  - Any cycle with `s[i] == db[i]` clears the counter, so a glitch restarts the count.
- FSM states: IDLE, OPEN, DONE.
  - IDLE: `start` = 1 moves to OPEN. The window counter loads 0 and the tally register `t` loads 0.
  - OPEN: the window counter (width clog2(WIN_CYC+1)) increments each cycle and `t` is updated as described under Configuration. When the counter equals WIN_CYC-1, the FSM moves to DONE, `sw3` loads the final tally and `valid` is asserted for the next cycle only.
  - DONE: a one-cycle state that returns to IDLE.
- `start` while in OPEN or DONE is ignored; it is not queued.
- `sw3` holds the previous ballot through IDLE and OPEN. It changes only on window close.
- `busy` = 1 exactly while the state is OPEN.

## Timing
- Reset values:
  - Outputs: `sw3` = 3'b000, `valid` = 0, `busy` = 0.
  - Internal: `db` = 0, all counters 0, synchroniser flops 0, state IDLE.
- Input to debounced: a clean edge on `sw_in` reaches `db` 2 + DB_CYC cycles later.
- Window timing:
  - `start` sampled high in cycle T gives `busy` high in cycles T+1 … T+WIN_CYC.
  - `sw3` updates and `valid` = 1 in cycle T+WIN_CYC+1.
  - The earliest accepted next `start` is in cycle T+WIN_CYC+2, i.e. back in IDLE.
- The tally includes the value of `db` in the last OPEN cycle, T+WIN_CYC.
- Asserting `rst_n` low at any point, including mid-window, immediately forces all reset values; the pending ballot is discarded and no `valid` is produced.
- A `start` held high continuously gives back-to-back windows, one every WIN_CYC+2 cycles.

## Configuration
- `VOTE_LOCK_EN`
  - Defined: a vote is latching within a window. Each OPEN cycle, `t <= t | db`, so a voter who shows 1 at any time during the window cannot retract. `sw3` = accumulated `t`.
  - Undefined: `t <= db` each OPEN cycle, so `sw3` equals `db` as sampled in the last OPEN cycle. Retractions count.

## Test plan
All scenarios use DB_CYC=4 and WIN_CYC=16.
- Reset: hold `rst_n` low with `sw_in` = 3'b111 → `sw3` = 000, `valid` = 0, `busy` = 0. After release, `db` = 111 within 6 cycles, but `sw3` stays 000 because no window has run.
- Bounce: toggle `sw_in[0]` every 2 cycles for 20 cycles, then hold it at 1 → `db[0]` stays 0 during toggling and becomes 1 exactly 6 cycles after the final edge.
- Basic window: `sw_in` = 3'b011 stable, one-cycle `start` at T → `busy` high T+1..T+16; `valid` pulses at T+17 with `sw3` = 011; `sw3` then holds 011 after `sw_in` changes.
- Retraction: `sw_in` = 3'b110 at window open, drops to 3'b010 mid-window with the 4-cycle debounce complete before close:
  - Without `VOTE_LOCK_EN` → `sw3` = 010.
  - With `VOTE_LOCK_EN` → `sw3` = 110.
- Ignored start: pulse `start` again at T+5 and T+17 → exactly one `valid`, at T+17, and `busy` is not extended. A `start` at T+18 is accepted.
- Mid-window reset: assert `rst_n` at T+8 → `busy` drops immediately, `sw3` = 000, and no `valid` pulse appears afterwards.
